ps2_rx_frame: RTL
=================

// Module: ps2_rx_frame
// PURPOSE
// - Receives PS/2 keyboard frames on ps2_clk/ps2_data and produces one scancode byte per completed key event.
// - Strips the E0 (extended) and F0 (break) prefixes into flags.
// - Sits directly upstream of the PS/2 scancode-to-button-vector decoder.
// - key_byte feeds that decoder; key_break tells the board logic to release rather than press.
// PARAMETERS
// - SYNC_STAGES     2      flip-flop stages on ps2_clk and ps2_data (min 2)
// - FILTER_LEN      4      consecutive equal synced ps2_clk samples needed to change the filtered clock
// - TIMEOUT_CYCLES  50000  idle cycles before a partial frame is aborted (PS2_RX_TIMEOUT_EN only)
// PORTS
// - clk        in   1  system clock; all logic on rising edge
// - reset      in   1  synchronous, active-high reset
// - ps2_clk    in   1  raw PS/2 clock, asynchronous, idles high
// - ps2_data   in   1  raw PS/2 data, asynchronous, idles high
// - key_byte   out  8  last accepted non-prefix scancode
// - key_valid  out  1  one-cycle pulse: key_byte/key_break/key_ext updated this cycle
// - key_break  out  1  1 = F0 preceded key_byte (key release)
// - key_ext    out  1  1 = E0 preceded key_byte
// - frame_err  out  1  one-cycle pulse on parity, stop or timeout error
// - busy       out  1  1 while the FSM is not in IDLE
// BEHAVIOUR
// - Reset values: key_byte=8'h00, key_valid=0, key_break=0, key_ext=0, frame_err=0, busy=0.
//   Reset also forces FSM=IDLE, filtered clock=1, synchronizers=1, and clears pending flags.
// - Reset mid-frame discards the partial frame with no error pulse.
// - Input conditioning:
//   - both inputs pass SYNC_STAGES flip-flops;
//   - the filtered clock takes the synced value only after FILTER_LEN consecutive equal samples;
//   - a "fall" is a 1->0 transition of the filtered clock.
// - ps2_data is sampled on the same cycle the fall is detected.
// - FSM, advancing only on a fall:
//   - IDLE: data=0 -> DATA, bitcnt=0; data=1 -> stay in IDLE (spurious clock ignored).
//   - DATA: shift data into the byte LSB-first; bitcnt++; after the 8th bit -> PARITY.
//   - PARITY: capture the parity bit -> STOP.
//   - STOP: capture the stop bit -> IDLE; the frame is evaluated on this same edge.
// - Frame is good when stop=1 AND ^{byte,parity}=1 (odd parity).
// - Good frame handling:
//   - byte=8'hF0: set break_pend; no output.
//   - byte=8'hE0: set ext_pend; no output.
//   - any other byte: on the next cycle key_valid=1, key_byte=byte, key_break=break_pend, key_ext=ext_pend; then clear both pendings.
// - Bad frame: frame_err=1 for one cycle (same timing as key_valid); both pendings cleared; key_* unchanged.
// - key_valid and frame_err are never asserted together.
// - key_byte, key_break and key_ext hold their values until the next key_valid.
// - Latency: key_valid rises exactly 1 clk after the cycle the stop-bit fall is detected.
// - Repeated F0/E0 prefixes are idempotent: pendings stay set, nothing is emitted.
// - busy=1 in DATA, PARITY and STOP.
// CONFIGURATION
// - PS2_RX_TIMEOUT_EN defined:
//   - a cycle counter runs while FSM != IDLE and resets on every fall;
//   - on reaching TIMEOUT_CYCLES-1: FSM -> IDLE, frame_err pulses one cycle, pendings cleared;
//   - the counter is held at 0 in IDLE.
// - PS2_RX_TIMEOUT_EN undefined:
//   - no counter logic; a partial frame waits indefinitely for its remaining falls;
//   - TIMEOUT_CYCLES is unused.
// TESTING
// - T1 0x1D frame (start 0, data 1,0,1,1,1,0,0,0, parity 1, stop 1)
//   -> one key_valid, key_byte=8'h1D, key_break=0, key_ext=0.
// - T2 frames F0 then 1C -> exactly one key_valid, key_byte=8'h1C, key_break=1; no pulse for F0.
// - T3 frames E0,F0,75 -> one key_valid, key_byte=8'h75, key_ext=1, key_break=1.
//   A following 0x24 frame gives key_break=0, key_ext=0.
// - T4 0x24 frame with parity bit 0
//   -> frame_err pulse, no key_valid, key_byte keeps its prior value, busy=0 afterwards.
// - T5 2-cycle low glitch on ps2_clk while idle (FILTER_LEN=4) -> no FSM movement, busy stays 0.
//   Then reset asserted after 4 data bits -> busy=0 next cycle; a following 0x2B frame decodes correctly.
// - T6 (PS2_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100) stop after 5 data bits
//   -> frame_err pulses ~100 cycles after the last fall, busy=0; the next 0x1B frame gives key_byte=8'h1B.

Source files
------------

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: synchronises and de-glitches ps2_clk/ps2_data, then emits one scancode per key
// event with the E0/F0 prefixes folded into flags. Define PS2_RX_TIMEOUT_EN to abort stalled frames.
module ps2_rx_frame #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_byte,
    output logic       key_valid,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic                   clk_s, dat_s, fall;
    logic                   filt_q, filt_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    state_e                 state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
    logic [7:0]             key_byte_q, key_byte_d;
    logic                   key_valid_q, key_valid_d, key_break_q, key_break_d;
    logic                   key_ext_q, key_ext_d, frame_err_q, frame_err_d, busy_q, busy_d;
    logic                   tmo_hit;

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_s      = clk_sync_q[SYNC_STAGES-1];
        dat_s      = dat_sync_q[SYNC_STAGES-1];
        fcnt_d     = '0;
        filt_d     = filt_q;
        if (clk_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
            else                               fcnt_d = fcnt_q + FW'(1);
        end
        fall = filt_q & ~filt_d;
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q, tmo_d;

    // A fall in the same cycle as expiry wins: the frame is still alive.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = (state_q != S_IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        if (state_q != S_IDLE && !fall && !tmo_hit) tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        brk_pend_d  = brk_pend_q;
        ext_pend_d  = ext_pend_q;
        key_byte_d  = key_byte_q;
        key_break_d = key_break_q;
        key_ext_d   = key_ext_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (tmo_hit) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            brk_pend_d  = 1'b0;
            ext_pend_d  = 1'b0;
        end else if (fall) begin
            unique case (state_q)
                S_IDLE: if (!dat_s) begin
                    state_d  = S_DATA;
                    bitcnt_d = 3'd0;
                end
                S_DATA: begin
                    shreg_d  = {dat_s, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (dat_s && ^{shreg_q, par_q}) begin
                        if (shreg_q == 8'hF0)      brk_pend_d = 1'b1;
                        else if (shreg_q == 8'hE0) ext_pend_d = 1'b1;
                        else begin
                            key_valid_d = 1'b1;
                            key_byte_d  = shreg_q;
                            key_break_d = brk_pend_q;
                            key_ext_d   = ext_pend_q;
                            brk_pend_d  = 1'b0;
                            ext_pend_d  = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        brk_pend_d  = 1'b0;
                        ext_pend_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= S_IDLE;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 8'h00;
            par_q       <= 1'b0;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            key_byte_q  <= 8'h00;
            key_valid_q <= 1'b0;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            brk_pend_q  <= brk_pend_d;
            ext_pend_q  <= ext_pend_d;
            key_byte_q  <= key_byte_d;
            key_valid_q <= key_valid_d;
            key_break_q <= key_break_d;
            key_ext_q   <= key_ext_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign key_byte  = key_byte_q;
    assign key_valid = key_valid_q;
    assign key_break = key_break_q;
    assign key_ext   = key_ext_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
endmodule
